// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT core.
// Bit-reversed load, one butterfly per cycle, natural-order unload.
module fft_r2_iter #(
  parameter int N     = 32,
  parameter int W     = 8,
  parameter int TW    = 8,
  parameter int SCALE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [2*W-1:0]          in_data,
  output logic                    in_ready,
  output logic [$clog2(N)-2:0]    tw_idx,
  input  logic signed [TW-1:0]    tw_re,
  input  logic signed [TW-1:0]    tw_im,
  output logic                    out_valid,
  output logic [2*W-1:0]          out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int L  = $clog2(N);
  localparam int SW = $clog2(L);
  localparam int PW = W + TW + 1;

  localparam logic [L-1:0]  LAST  = L'(N - 1);
  localparam logic [L-2:0]  JLAST = (L-1)'(N/2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(L - 1);

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    UNLOAD
  } state_t;

  state_t         state;
  logic [L-1:0]   load_cnt;
  logic [L-1:0]   out_cnt;
  logic [L-2:0]   j;
  logic [SW-1:0]  s;
  logic [2*W-1:0] mem [N];

  function automatic logic [L-1:0] bitrev(
    input logic [L-1:0] v
  );
    for (int i = 0; i < L; i++)
      bitrev[i] = v[L-1-i];
  endfunction

  logic [L-1:0] jx;
  logic [L-1:0] half;
  logic [L-1:0] pos;
  logic [L-1:0] p;
  logic [L-1:0] q;
  logic [L-2:0] tw_c;

  assign jx   = {1'b0, j};
  assign half = L'(1) << s;
  assign pos  = jx & (half - 1'b1);
  assign p    = (((jx >> s) << s) << 1) | pos;
  assign q    = p | half;
  assign tw_c = (L-1)'(pos << (L - 1 - s));

  logic signed [W-1:0] ar;
  logic signed [W-1:0] ai;
  logic signed [W-1:0] br;
  logic signed [W-1:0] bi;

  assign {ai, ar} = mem[p];
  assign {bi, br} = mem[q];

  logic signed [PW-1:0] brx;
  logic signed [PW-1:0] bix;
  logic signed [PW-1:0] twr;
  logic signed [PW-1:0] twi;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pi;

  assign brx = PW'(br);
  assign bix = PW'(bi);
  assign twr = PW'(tw_re);
  assign twi = PW'(tw_im);
  assign pr  = brx * twr - bix * twi;
  assign pi  = brx * twi + bix * twr;

  // floor shift by TW-2 then keep W+1 bits is a plain slice
  logic signed [W:0] tr;
  logic signed [W:0] ti;

  assign tr = pr[TW-2 +: W+1];
  assign ti = pi[TW-2 +: W+1];

  logic signed [W+1:0] spr;
  logic signed [W+1:0] spi;
  logic signed [W+1:0] sqr;
  logic signed [W+1:0] sqi;

  assign spr = (W+2)'(ar) + (W+2)'(tr);
  assign spi = (W+2)'(ai) + (W+2)'(ti);
  assign sqr = (W+2)'(ar) - (W+2)'(tr);
  assign sqi = (W+2)'(ai) - (W+2)'(ti);

  logic [W-1:0] npr;
  logic [W-1:0] npi;
  logic [W-1:0] nqr;
  logic [W-1:0] nqi;

  assign npr = (SCALE != 0) ? spr[W:1] : spr[W-1:0];
  assign npi = (SCALE != 0) ? spi[W:1] : spi[W-1:0];
  assign nqr = (SCALE != 0) ? sqr[W:1] : sqr[W-1:0];
  assign nqi = (SCALE != 0) ? sqi[W:1] : sqi[W-1:0];

  logic unused_bits;
  assign unused_bits = ^{pr, pi, spr, spi, sqr, sqi};

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem[bitrev(load_cnt)] <= in_data;
    end else if (state == CALC) begin
      mem[p] <= {npi, npr};
      mem[q] <= {nqi, nqr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      out_cnt  <= '0;
      s        <= '0;
      j        <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == LAST)
              state <= CALC;
          end
        end
        CALC: begin
          j <= j + 1'b1;
          if (j == JLAST) begin
            s <= s + 1'b1;
            if (s == SLAST) begin
              s     <= '0;
              state <= UNLOAD;
            end
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LAST)
              state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == UNLOAD);
  assign busy      = (state == CALC);
  assign out_last  = (state == UNLOAD) && (out_cnt == LAST);
  assign out_data  = (state == UNLOAD) ? mem[out_cnt] : '0;
  assign tw_idx    = (state == CALC) ? tw_c : '0;

endmodule

// File: tb/tb_fft_r2_iter.sv
// Bench for fft_r2_iter: SCALE=0 and SCALE=1 cores side by side,
// scoreboarded against a textbook DIT reference.
module tb_fft_r2_iter;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int TW = 8;
  localparam real PI = 3.141592653589793;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1;
  logic [3:0]  tw_idx0, tw_idx1;
  logic signed [7:0] twr0, twi0, twr1, twi1;
  logic        ov0, ov1, ol0, ol1, busy0, busy1;
  logic [15:0] od0, od1;

  logic signed [7:0] rom_re [16];
  logic signed [7:0] rom_im [16];

  always #5 clk = ~clk;

  assign twr0 = rom_re[tw_idx0];
  assign twi0 = rom_im[tw_idx0];
  assign twr1 = rom_re[tw_idx1];
  assign twi1 = rom_im[tw_idx1];

  fft_r2_iter #(.N(N), .W(W), .TW(TW), .SCALE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready0),
    .tw_idx(tw_idx0), .tw_re(twr0), .tw_im(twi0),
    .out_valid(ov0), .out_data(od0), .out_last(ol0),
    .out_ready(out_ready), .busy(busy0)
  );

  fft_r2_iter #(.N(N), .W(W), .TW(TW), .SCALE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready1),
    .tw_idx(tw_idx1), .tw_re(twr1), .tw_im(twi1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1),
    .out_ready(out_ready), .busy(busy1)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        last;
  } exp_t;

  exp_t        q [$];
  exp_t        mon_e;
  int          ncmp = 0;
  int          nerr = 0;
  int          popped = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [15:0] exp3_0, exp3_1;

  always @(posedge clk) cyc++;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int wrap(input int v, input int n);
    int m;
    m = v & ((1 << n) - 1);
    if (m >= (1 << (n - 1))) m -= (1 << n);
    return m;
  endfunction

  // Reference: bit-reverse, then classic group/butterfly loops
  function automatic void model(
    input  logic [15:0] x [32],
    input  int          sc,
    output logic [15:0] y [32]
  );
    int re [32];
    int im [32];
    for (int i = 0; i < 32; i++) begin
      int r;
      r = 0;
      for (int b = 0; b < 5; b++)
        if (i[b]) r |= 1 << (4 - b);
      re[r] = wrap(int'(x[i][7:0]), 8);
      im[r] = wrap(int'(x[i][15:8]), 8);
    end
    for (int s = 0; s < 5; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < 32; g += 2 * h) begin
        for (int m = 0; m < h; m++) begin
          int k, a, b, tr, ti, pr, pi, qr, qi;
          k = m * (16 / h);
          a = g + m;
          b = a + h;
          tr = wrap((re[b] * rom_re[k] - im[b] * rom_im[k]) >>> 6, 9);
          ti = wrap((re[b] * rom_im[k] + im[b] * rom_re[k]) >>> 6, 9);
          pr = re[a] + tr;
          pi = im[a] + ti;
          qr = re[a] - tr;
          qi = im[a] - ti;
          if (sc != 0) begin
            pr = pr >>> 1;
            pi = pi >>> 1;
            qr = qr >>> 1;
            qi = qi >>> 1;
          end
          re[a] = wrap(pr, 8);
          im[a] = wrap(pi, 8);
          re[b] = wrap(qr, 8);
          im[b] = wrap(qi, 8);
        end
      end
    end
    for (int i = 0; i < 32; i++)
      y[i] = {8'(im[i]), 8'(re[i])};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (ov0 || ov1) && out_ready) begin
      ncmp++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_bin: got %h/%h, required no output", od0, od1);
      end else begin
        mon_e = q.pop_front();
        if ({ov0, ov1, od0, od1, ol0, ol1} !==
            {2'b11, mon_e.d0, mon_e.d1, mon_e.last, mon_e.last}) begin
          nerr++;
          $display("FAIL bin%0d: got v=%b%b d=%h/%h last=%b%b, required d=%h/%h last=%b",
                   popped % 32, ov0, ov1, od0, od1, ol0, ol1,
                   mon_e.d0, mon_e.d1, mon_e.last);
        end
        popped++;
      end
    end
  end

  task automatic expect_frame(input logic [15:0] x [32]);
    logic [15:0] y0 [32];
    logic [15:0] y1 [32];
    model(x, 0, y0);
    model(x, 1, y1);
    for (int b = 0; b < 32; b++)
      q.push_back('{y0[b], y1[b], (b == 31)});
    exp3_0 = y0[3];
    exp3_1 = y1[3];
  endtask

  task automatic send(input logic [15:0] x [32], input bit gaps, input bit hold);
    int i, g;
    i = 0;
    g = 0;
    @(posedge clk); #1;
    while (i < 32 && g < 400) begin
      in_valid = gaps ? (g % 2 == 0) : 1'b1;
      in_data  = x[i];
      if (in_valid && in_ready0) begin
        acc_cyc = cyc;
        i++;
      end
      @(posedge clk); #1;
      g++;
    end
    in_valid = hold;
    in_data  = hold ? 16'h5a5a : 16'h0000;
    chk("samples_accepted", i, 32);
  endtask

  task automatic run_frame(
    input logic [15:0] x [32],
    input bit gaps, input bit hold, input bit bp, input bit stage_chk
  );
    int base, ok, nb, bad, lat;
    base = popped;
    ok = 0;
    nb = 0;
    bad = 0;
    lat = -1;
    expect_frame(x);
    send(x, gaps, hold);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ov0) begin
        ok = 1;
        lat = cyc - acc_cyc;
        break;
      end
      if (busy0 && busy1) begin
        nb++;
        if (nb <= 16 && (tw_idx0 != 0 || tw_idx1 != 0)) bad++;
      end
    end
    if (hold) in_valid = 1'b0;
    chk("latency", lat, 81);
    if (stage_chk) begin
      chk("busy_cycles", nb, 80);
      chk("stage0_twidx_nonzero", bad, 0);
    end
    if (bp && ok != 0) begin
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (popped - base == 3) break;
      end
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("bp_valid", ov0 & ov1, 1);
        chk("bp_hold_s0", od0, exp3_0);
        chk("bp_hold_s1", od1, exp3_1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    for (int k = 0; k < 400; k++) begin
      if (popped - base >= 32) break;
      @(negedge clk);
    end
    chk("handshakes", popped - base, 32);
    @(posedge clk); #1;
    chk("in_ready_after", in_ready0 & in_ready1, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] x [32];
    int nb;
    for (int k = 0; k < 16; k++) begin
      rom_re[k] = 8'(rnd(64.0 * $cos(2.0 * PI * k / 32.0)));
      rom_im[k] = 8'(rnd(-64.0 * $sin(2.0 * PI * k / 32.0)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0 & in_ready1, 1);
    chk("rst_out_valid", ov0 | ov1, 0);
    chk("rst_busy", busy0 | busy1, 0);
    chk("rst_out_last", ol0 | ol1, 0);
    chk("rst_tw_idx", tw_idx0 | tw_idx1, 0);
    chk("rst_out_data", od0 | od1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (x[i]) x[i] = (i == 0) ? 16'h0001 : 16'h0000;
    run_frame(x, 0, 0, 0, 0);

    foreach (x[i]) x[i] = 16'h0001;
    run_frame(x, 0, 0, 0, 0);

    foreach (x[i]) x[i] = 16'h0040;
    run_frame(x, 0, 0, 0, 1);

    repeat (2) begin
      foreach (x[i]) x[i] = 16'($urandom);
      run_frame(x, 0, 0, 0, 0);
    end

    foreach (x[i]) x[i] = 16'($urandom);
    run_frame(x, 0, 0, 1, 0);

    foreach (x[i]) x[i] = 16'h0001;
    run_frame(x, 1, 1, 0, 0);

    foreach (x[i]) x[i] = 16'($urandom);
    send(x, 0, 0);
    nb = 0;
    for (int k = 0; k < 200 && nb < 40; k++) begin
      @(negedge clk);
      if (busy0) nb++;
    end
    chk("calc_cycles_before_reset", nb, 40);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready0 & in_ready1, 1);
    chk("mid_rst_out_valid", ov0 | ov1, 0);
    chk("mid_rst_busy", busy0 | busy1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (x[i]) x[i] = (i == 0) ? 16'h0001 : 16'h0000;
    run_frame(x, 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
